// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg
//   Shared definitions for the display scan controller:
//   - scan FSM state encoding (IDLE / BLANK / ON)
//   - BCD digit width
//   - common-anode digit-enable polarity (enable is active-low)
package seg_scan_ctrl_pkg;

    // Width of one packed BCD digit.
    localparam int BCD_W = 4;

    // Common-anode display: a digit is lit by pulling its enable low.
    localparam logic DIGIT_ON  = 1'b0;
    localparam logic DIGIT_OFF = 1'b1;

    // Scan FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_load.sv
// seg_scan_ctrl_load
//   Input side of the scan controller. Checks every digit of the incoming
//   packed BCD word, replaces out-of-range digits with 0 and marks them dark,
//   and keeps the latest loaded word in the pending register.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   din        in   packed BCD value, digit i at din[4i+3:4i]
//   din_valid  in   one-cycle load strobe
//   clean_val  out  combinational sanitized din (bad digits forced to 0)
//   clean_dark out  combinational per-digit flag: din digit was > 9
//   pend_val   out  registered sanitized value of the last load
//   pend_dark  out  registered dark flags of the last load
//   bcd_err    out  sticky: some loaded digit was > 9
import seg_scan_ctrl_pkg::*;

module seg_scan_ctrl_load #(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BCD_W*DIGITS-1:0]   din,
    input  logic                      din_valid,
    output logic [BCD_W*DIGITS-1:0]   clean_val,
    output logic [DIGITS-1:0]         clean_dark,
    output logic [BCD_W*DIGITS-1:0]   pend_val,
    output logic [DIGITS-1:0]         pend_dark,
    output logic                      bcd_err
);

    logic [BCD_W*DIGITS-1:0] pend_val_reg;
    logic [DIGITS-1:0]       pend_dark_reg;
    logic                    bcd_err_reg;

    // Per-digit range check. A bad code is replaced by 0 so it can never
    // reach the decoder, and remembered as dark so it is never lit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [BCD_W-1:0] code;
            assign code                          = din[gi*BCD_W +: BCD_W];
            assign clean_dark[gi]                = (code > BCD_W'(9));
            assign clean_val[gi*BCD_W +: BCD_W]  = clean_dark[gi] ? '0 : code;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val_reg  <= '0;
            pend_dark_reg <= '0;
            bcd_err_reg   <= 1'b0;
        end else if (din_valid) begin
            pend_val_reg  <= clean_val;
            pend_dark_reg <= clean_dark;
            if (|clean_dark) begin
                bcd_err_reg <= 1'b1;
            end
        end
    end

    assign pend_val  = pend_val_reg;
    assign pend_dark = pend_dark_reg;
    assign bcd_err   = bcd_err_reg;

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a common-anode multi-digit display
//   sharing one external BCD-to-7-segment decoder. Each digit slot is
//   SCAN_DIV cycles: BLANK_CYC dark cycles (num settles here) followed by
//   the digit being enabled. The displayed value (shadow) only changes at a
//   frame boundary so a frame never mixes old and new digits.
//
// Parameters:
//   DIGITS     number of digit positions (2..8), digit 0 least significant
//   SCAN_DIV   cycles per digit slot, blank included (> BLANK_CYC)
//   BLANK_CYC  dark cycles at the start of every slot (>= 1)
//
// Ports:
//   sys_clk      in   clock, rising edge
//   sys_rst      in   asynchronous active-high reset
//   scan_en      in   1 = scan, 0 = dark and idle
//   lz_en        in   1 = suppress leading zeros (digit 0 never suppressed)
//   din          in   packed BCD value
//   din_valid    in   one-cycle load strobe for din
//   num          out  BCD code to the shared decoder, always 0..9
//   digit_sel_n  out  active-low digit enables, one-cold or all ones
//   frame_done   out  one-cycle pulse when the last slot of a frame ends
//   bcd_err      out  sticky flag: a loaded digit was > 9
import seg_scan_ctrl_pkg::*;

module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     scan_en,
    input  logic                     lz_en,
    input  logic [BCD_W*DIGITS-1:0]  din,
    input  logic                     din_valid,
    output logic [BCD_W-1:0]         num,
    output logic [DIGITS-1:0]        digit_sel_n,
    output logic                     frame_done,
    output logic                     bcd_err
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]     ON_LAST    = CW'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ALL_OFF    = {DIGITS{DIGIT_OFF}};

    // Loader outputs
    logic [BCD_W*DIGITS-1:0] clean_val;
    logic [DIGITS-1:0]       clean_dark;
    logic [BCD_W*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]       pend_dark;

    // Scan state
    scan_state_t             state_reg;
    logic [CW-1:0]           cnt_reg;
    logic [IW-1:0]           idx_reg;
    logic [BCD_W*DIGITS-1:0] shadow_val_reg;
    logic [DIGITS-1:0]       shadow_dark_reg;
    logic [BCD_W-1:0]        num_reg;
    logic [DIGITS-1:0]       sel_n_reg;
    logic                    frame_done_reg;

    // Derived combinational values
    logic [BCD_W*DIGITS-1:0] copy_val;
    logic [DIGITS-1:0]       copy_dark;
    logic [BCD_W-1:0]        cur_digit;
    logic [DIGITS-1:0]       lz_mask_w;
    logic [DIGITS-1:0]       on_pattern;
    logic                    suppress;

    seg_scan_ctrl_load #(
        .DIGITS (DIGITS)
    ) u_load (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .din        (din),
        .din_valid  (din_valid),
        .clean_val  (clean_val),
        .clean_dark (clean_dark),
        .pend_val   (pend_val),
        .pend_dark  (pend_dark),
        .bcd_err    (bcd_err)
    );

    // Bit i set when digit i (i > 0) and every digit above it are zero,
    // i.e. digit i is a leading zero.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [BCD_W*DIGITS-1:0] v);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (v[i*BCD_W +: BCD_W] == '0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    // A load in the same cycle as the frame-boundary copy bypasses pend,
    // so the new value is shown starting with the frame that begins now.
    assign copy_val  = din_valid ? clean_val  : pend_val;
    assign copy_dark = din_valid ? clean_dark : pend_dark;

    assign cur_digit = shadow_val_reg[int'(idx_reg)*BCD_W +: BCD_W];
    assign lz_mask_w = lz_mask(shadow_val_reg);
    assign suppress  = shadow_dark_reg[idx_reg] | (lz_en & lz_mask_w[idx_reg]);

    always_comb begin
        on_pattern          = ALL_OFF;
        on_pattern[idx_reg] = DIGIT_ON;
    end

    // Scan FSM. All outputs are registered here; num is only reloaded while
    // in BLANK, so it is stable whenever a digit is enabled.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            shadow_val_reg  <= '0;
            shadow_dark_reg <= '0;
            num_reg         <= '0;
            sel_n_reg       <= ALL_OFF;
            frame_done_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (!scan_en) begin
                // Dark immediately; shadow is deliberately kept.
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
                idx_reg   <= '0;
                num_reg   <= '0;
                sel_n_reg <= ALL_OFF;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg       <= ST_BLANK;
                        cnt_reg         <= '0;
                        idx_reg         <= '0;
                        shadow_val_reg  <= copy_val;
                        shadow_dark_reg <= copy_dark;
                    end
                    ST_BLANK: begin
                        num_reg <= cur_digit;
                        if (cnt_reg == BLANK_LAST) begin
                            state_reg <= ST_ON;
                            cnt_reg   <= '0;
                            // lz_en takes effect per slot, here on ON entry.
                            sel_n_reg <= suppress ? ALL_OFF : on_pattern;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    ST_ON: begin
                        if (cnt_reg == ON_LAST) begin
                            state_reg <= ST_BLANK;
                            cnt_reg   <= '0;
                            sel_n_reg <= ALL_OFF;
                            if (idx_reg == IDX_LAST) begin
                                idx_reg         <= '0;
                                frame_done_reg  <= 1'b1;
                                shadow_val_reg  <= copy_val;
                                shadow_dark_reg <= copy_dark;
                            end else begin
                                idx_reg <= idx_reg + 1'b1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                        num_reg   <= '0;
                        sel_n_reg <= ALL_OFF;
                    end
                endcase
            end
        end
    end

    assign num         = num_reg;
    assign digit_sel_n = sel_n_reg;
    assign frame_done  = frame_done_reg;

endmodule
